// File: rtl/status_register_unit_pkg.sv
// Shared status-flag constants and types used by the ALU, the condition check
// and the status register unit.
package status_register_unit_pkg;

  localparam int unsigned STATUS_LEN    = 4;
  localparam int unsigned CNT_WIDTH_DEF = 8;

  // Bit positions inside the {z, c, n, v} status word
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [STATUS_LEN-1:0] STATUS_RESET = 4'b0000;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } status_t;

  function automatic logic [STATUS_LEN-1:0] pack_status(input logic z, input logic c,
                                                        input logic n, input logic v);
    status_t s;
    s.z = z;
    s.c = c;
    s.n = n;
    s.v = v;
    return STATUS_LEN'(s);
  endfunction

endpackage

// File: rtl/status_register_unit_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  logic [WIDTH-1:0] r_count;
  logic             w_can_inc;

  assign w_can_inc = i_en & (r_count != COUNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_can_inc) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/status_register_unit.sv
// Architectural NZCV status register with EXE-stage commit, ID-stage bypass or
// condition-hazard stall, and a saturating flag-update counter for debug.
module status_register_unit #(
  parameter int unsigned STATUS_LEN = status_register_unit_pkg::STATUS_LEN,
  parameter int unsigned FORWARD_EN = 1,
  parameter int unsigned CNT_WIDTH  = status_register_unit_pkg::CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_s,
  input  logic                  id_cond_used,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic [STATUS_LEN-1:0] alu_status,
  output logic [STATUS_LEN-1:0] status_to_cond,
  output logic [STATUS_LEN-1:0] status_reg_out,
  output logic                  cond_hazard,
  output logic                  exe_s_pending,
  output logic [CNT_WIDTH-1:0]  update_count
);

  import status_register_unit_pkg::*;

  logic                  r_exe_s_pending;
  logic [STATUS_LEN-1:0] r_status_reg;
  logic                  w_cond_hazard;
  logic                  w_advance;
  logic                  w_commit;
  logic [STATUS_LEN-1:0] w_status_to_cond;

  // Bypass the in-flight EXE flags, or stall ID while they are still pending
  always_comb begin
    w_cond_hazard    = 1'b0;
    w_status_to_cond = r_status_reg;
    if (FORWARD_EN != 0) begin
      if (r_exe_s_pending) begin
        w_status_to_cond = alu_status;
      end
    end else begin
      w_cond_hazard = id_valid & id_cond_used & r_exe_s_pending;
    end
  end

  assign w_advance = ~freeze & ~w_cond_hazard;
  assign w_commit  = r_exe_s_pending & ~freeze;

  // S bit of the instruction in EXE; freeze beats flush, flush beats advance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exe_s_pending <= 1'b0;
    end else if (!freeze && flush) begin
      r_exe_s_pending <= 1'b0;
    end else if (w_advance) begin
      r_exe_s_pending <= id_valid & id_s;
    end
  end

  // Commit happens on the single unfrozen edge that moves the setter out of EXE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_status_reg <= STATUS_LEN'(STATUS_RESET);
    end else if (w_commit) begin
      r_status_reg <= alu_status;
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_update_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_commit),
    .o_count (update_count)
  );

  assign status_to_cond = w_status_to_cond;
  assign status_reg_out = r_status_reg;
  assign cond_hazard    = w_cond_hazard;
  assign exe_s_pending  = r_exe_s_pending;

endmodule

// File: tb/tb_status_register_unit.sv
// Scoreboard bench: one forwarding DUT (8-bit counter) and one stalling DUT
// (2-bit counter) share stimulus and are checked against a behavioural model.
module tb_status_register_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic       id_s = 1'b0;
  logic       id_cond_used = 1'b0;
  logic       freeze = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] alu_status = 4'b0000;

  logic [3:0] stc_f, sro_f, stc_s, sro_s;
  logic       haz_f, pend_f, haz_s, pend_s;
  logic [7:0] cnt_f;
  logic [1:0] cnt_s;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] stc_f;
    logic [3:0] sro_f;
    logic       haz_f;
    logic       pend_f;
    int         cnt_f;
    logic [3:0] stc_s;
    logic [3:0] sro_s;
    logic       haz_s;
    logic       pend_s;
    int         cnt_s;
  } exp_t;

  exp_t q[$];

  // Reference state: flags the architecture holds, and whether a setter is in EXE
  logic       m_pend_f, m_pend_s;
  logic [3:0] m_sreg_f, m_sreg_s;
  int         m_cnt_f, m_cnt_s;

  always #5 clk = ~clk;

  status_register_unit #(.STATUS_LEN(4), .FORWARD_EN(1), .CNT_WIDTH(8)) dut_f (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_s(id_s), .id_cond_used(id_cond_used),
    .freeze(freeze), .flush(flush), .alu_status(alu_status),
    .status_to_cond(stc_f), .status_reg_out(sro_f), .cond_hazard(haz_f),
    .exe_s_pending(pend_f), .update_count(cnt_f)
  );

  status_register_unit #(.STATUS_LEN(4), .FORWARD_EN(0), .CNT_WIDTH(2)) dut_s (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_s(id_s), .id_cond_used(id_cond_used),
    .freeze(freeze), .flush(flush), .alu_status(alu_status),
    .status_to_cond(stc_s), .status_reg_out(sro_s), .cond_hazard(haz_s),
    .exe_s_pending(pend_s), .update_count(cnt_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the architectural behaviour for a single configuration
  task automatic model_edge(input bit fwd, input int maxc,
                            input logic v, input logic s, input logic cu,
                            input logic fr, input logic fl, input logic rs,
                            input logic [3:0] alu,
                            inout logic pend, inout logic [3:0] sreg, inout int cnt);
    bit stalled;
    stalled = !fwd && v && cu && pend;
    if (rs) begin
      pend = 1'b0;
      sreg = 4'b0000;
      cnt  = 0;
    end else if (!fr) begin
      if (pend) begin
        sreg = alu;
        cnt  = (cnt < maxc) ? cnt + 1 : maxc;
      end
      if (fl)            pend = 1'b0;
      else if (!stalled) pend = v && s;
    end
  endtask

  // Drive one cycle, queue the expected outputs, then advance the model past the edge
  task automatic step(input logic v, input logic s, input logic cu, input logic fr,
                      input logic fl, input logic rs, input logic [3:0] alu);
    exp_t e;
    id_valid = v; id_s = s; id_cond_used = cu;
    freeze = fr; flush = fl; rst = rs; alu_status = alu;
    e.stc_f  = m_pend_f ? alu : m_sreg_f;
    e.sro_f  = m_sreg_f;
    e.haz_f  = 1'b0;
    e.pend_f = m_pend_f;
    e.cnt_f  = m_cnt_f;
    e.stc_s  = m_sreg_s;
    e.sro_s  = m_sreg_s;
    e.haz_s  = v & cu & m_pend_s;
    e.pend_s = m_pend_s;
    e.cnt_s  = m_cnt_s;
    q.push_back(e);
    @(posedge clk);
    model_edge(1'b1, 255, v, s, cu, fr, fl, rs, alu, m_pend_f, m_sreg_f, m_cnt_f);
    model_edge(1'b0, 3,   v, s, cu, fr, fl, rs, alu, m_pend_s, m_sreg_s, m_cnt_s);
    #1;
  endtask

  // Monitor: every cycle presents a full output set, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("fwd.status_to_cond", 32'(stc_f),  32'(e.stc_f));
        chk("fwd.status_reg_out", 32'(sro_f),  32'(e.sro_f));
        chk("fwd.cond_hazard",    32'(haz_f),  32'(e.haz_f));
        chk("fwd.exe_s_pending",  32'(pend_f), 32'(e.pend_f));
        chk("fwd.update_count",   32'(cnt_f),  32'(e.cnt_f));
        chk("stl.status_to_cond", 32'(stc_s),  32'(e.stc_s));
        chk("stl.status_reg_out", 32'(sro_s),  32'(e.sro_s));
        chk("stl.cond_hazard",    32'(haz_s),  32'(e.haz_s));
        chk("stl.exe_s_pending",  32'(pend_s), 32'(e.pend_s));
        chk("stl.update_count",   32'(cnt_s),  32'(e.cnt_s));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_pend_f = 1'b0; m_sreg_f = 4'b0000; m_cnt_f = 0;
    m_pend_s = 1'b0; m_sreg_s = 4'b0000; m_cnt_s = 0;

    // Reset mid-stream with status 1010 and a setter pending
    step(1, 1, 0, 0, 0, 0, 4'b0000);
    step(1, 1, 0, 0, 0, 0, 4'b1010);
    step(0, 0, 0, 0, 0, 1, 4'b0110);
    step(1, 0, 1, 0, 0, 0, 4'b0000);

    // Setter then a condition reader: bypass on one DUT, 1-cycle stall on the other
    step(1, 1, 0, 0, 0, 0, 4'b0000);
    step(1, 0, 1, 0, 0, 0, 4'b1000);
    step(1, 0, 1, 0, 0, 0, 4'b1000);
    step(0, 0, 0, 0, 0, 0, 4'b0000);
    step(0, 0, 0, 0, 0, 0, 4'b0000);

    // Setter held in EXE by a 3-cycle freeze commits once
    step(1, 1, 0, 0, 0, 0, 4'b0000);
    repeat (3) step(0, 0, 0, 1, 1, 0, 4'b0100);
    step(0, 0, 0, 0, 0, 0, 4'b0100);
    step(0, 0, 0, 0, 0, 0, 4'b1111);

    // Flush squashes the ID transfer but not an older setter in EXE
    step(1, 1, 0, 0, 1, 0, 4'b1111);
    step(0, 0, 0, 0, 0, 0, 4'b1111);
    step(1, 1, 0, 0, 0, 0, 4'b0000);
    step(1, 1, 0, 0, 1, 0, 4'b0011);
    step(0, 0, 0, 0, 0, 0, 4'b1100);

    // Back-to-back setters drive the 2-bit counter into saturation
    step(0, 0, 0, 0, 0, 1, 4'b0000);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0, 4'(i + 1));
    step(0, 0, 0, 0, 0, 0, 4'b1001);
    step(0, 0, 0, 0, 0, 0, 4'b0000);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 49) == 0), 4'($urandom));
    end

    step(0, 0, 0, 0, 0, 0, 4'b0000);
    @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/status_register_unit.md
Name: status_register_unit

Overview:
- Holds the architectural NZCV status register that feeds the condition-check logic in the ID stage.
- Tracks the flag-setting (S) bit of the instruction moving from ID to EXE, and commits ALU flags at the end of EXE.
- Provides either a forwarded or a registered status to the condition check.
- When forwarding is disabled, raises a condition-hazard stall. Also keeps a saturating count of flag updates for debug.

Parameters:
- STATUS_LEN, 4, status width; bit order {z, c, n, v}, matching the condition-check input.
- FORWARD_EN, 1, 1 = bypass EXE flags to the condition check; 0 = stall instead.
- CNT_WIDTH, 8, width of the flag-update counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_s  in  1  ID instruction sets flags (S bit)
- id_cond_used  in  1  ID condition field is not AL
- freeze  in  1  global pipeline freeze (memory wait)
- flush  in  1  branch taken; squash the ID-to-EXE transfer
- alu_status  in  STATUS_LEN  {z, c, n, v} from the ALU for the EXE instruction
- status_to_cond  out  STATUS_LEN  status presented to the condition check
- status_reg_out  out  STATUS_LEN  architectural register value
- cond_hazard  out  1  stall request for ID/IF
- exe_s_pending  out  1  flag-setting instruction currently in EXE
- update_count  out  CNT_WIDTH  number of committed flag writes, saturating

Behaviour:
- Reset (rst=1 at a clk edge): status_reg=0, exe_s_pending=0, update_count=0.
  - Combinational outputs then read status_to_cond=0 and cond_hazard=0.
  - Reset overrides freeze and flush, and discards any write in progress.
- advance = ~freeze & ~cond_hazard.
- exe_s_pending register:
  - flush=1 → 0; flush has priority over advance but not over freeze.
  - Else advance=1 → id_valid & id_s.
  - Else hold.
  - freeze=1 holds the value even when flush=1. Flush is re-sampled after the freeze clears; the branch unit keeps flush asserted until then.
- Commit:
  - If exe_s_pending=1 and freeze=0 at a clk edge: status_reg ← alu_status, and update_count increments.
  - update_count saturates at 2^CNT_WIDTH−1 and does not wrap.
  - Under freeze, no commit; status_reg and the count hold.
  - Exactly one commit per flag-setting instruction, even if it sits in EXE for several frozen cycles.
- status_to_cond, FORWARD_EN=1: combinational bypass.
  - exe_s_pending=1 → alu_status.
  - Else → status_reg.
  - cond_hazard is tied to 0.
- status_to_cond, FORWARD_EN=0:
  - status_to_cond = status_reg.
  - cond_hazard = id_valid & id_cond_used & exe_s_pending.
  - While cond_hazard=1 the ID instruction does not advance, so exe_s_pending goes to 0 at the next unfrozen edge. The stall therefore lasts exactly 1 cycle (plus freeze cycles).
- status_reg_out = status_reg; latency is 1 cycle from commit.
- An ID instruction that both reads a condition and sets S has its condition evaluated against the older flags (forwarded or stalled). Its own flags commit one stage later.
- Simultaneous commit and advance on the same edge: allowed. Old EXE flags commit, and the new exe_s_pending loads from ID.
- flush while a flag setter sits in EXE: the EXE instruction still commits (it is older than the branch). Only the ID-side transfer is squashed.
- Back-to-back S instructions produce two commits in consecutive cycles; the count rises by 2.

Decomposition:
- Shared constants header holds:
  - STATUS_LEN;
  - the flag bit indices Z=3, C=2, N=1, V=0;
  - reset value STATUS_RESET=4'b0000.
- These are reused by the ALU and the condition-check logic.
- One natural sub-module: sat_counter (parameterised width, enable, synchronous reset, saturate). It is also reusable for other debug counters.
- The rest is flat: the pending flop, the status flop, and bypass/hazard logic.

Test Plan:
- Reset mid-stream: set status_reg=4'b1010 and exe_s_pending=1, assert rst for 1 cycle → status_reg_out=0, exe_s_pending=0, update_count=0, cond_hazard=0.
- Forwarding (FORWARD_EN=1): ID S-instruction advances; next cycle alu_status=4'b1000 and the ID instruction uses a condition → status_to_cond=4'b1000 in that same cycle, status_reg_out=4'b1000 one cycle later, update_count=1.
- Stall (FORWARD_EN=0): same sequence → cond_hazard=1 for exactly 1 cycle; status_to_cond shows the old value 4'b0000 during the stall and 4'b1000 the next cycle; cond_hazard=0 afterwards.
- Freeze: flag setter in EXE with freeze held 3 cycles, alu_status=4'b0100 → no change during freeze; a single commit after release; update_count increments by 1, not 4.
- Flush: id_s=1, id_valid=1, flush=1 → exe_s_pending=0 next cycle, no commit. With a flag setter already in EXE on the flush cycle → that commit still occurs.
- Saturation (CNT_WIDTH=2): 5 consecutive S instructions → update_count reads 1, 2, 3, 3, 3.
